// File: rtl/fir_sample_feeder.sv
// Coefficient shadow loader plus sample FIFO feeding a FIR datapath; x is registered one cycle after the FIFO.
// s_ready falls when the FIFO is full. The burst flush (n zero samples + done pulse) is enabled by FIR_FEED_FLUSH_EN.
module fir_sample_feeder #(
   parameter int n     = 2,
   parameter int w_x   = 8,
   parameter int w_h   = 8,
   parameter int depth = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  coef_valid,
   input  logic signed [w_h-1:0] coef_data,
   output logic                  coef_ready,
   input  logic                  reload,
   input  logic                  s_valid,
   input  logic signed [w_x-1:0] s_data,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic signed [w_x-1:0] x,
   output logic                  x_valid,
   output logic [(n+1)*w_h-1:0]  Hz,
   output logic                  done
);
   localparam int hw = (n + 1) * w_h;
   localparam int aw = $clog2(depth);
   localparam int cw = (n > 0) ? $clog2(n + 1) : 1;
   localparam logic [aw:0] full_cnt = (aw + 1)'(depth);
`ifdef FIR_FEED_FLUSH_EN
   localparam bit flush_en = 1'b1;
`else
   localparam bit flush_en = 1'b0;
`endif

   typedef enum logic [1:0] {LOAD, RUN, FLUSH} state_t;

   state_t                state_q, state_d;
   logic [hw-1:0]         shadow_q, shadow_d, shadow_nx;
   logic [hw-1:0]         hz_q, hz_d;
   logic [cw-1:0]         wcnt_q, wcnt_d;
   logic [cw-1:0]         fcnt_q, fcnt_d;
   logic [aw-1:0]         wr_ptr_q, wr_ptr_d;
   logic [aw-1:0]         rd_ptr_q, rd_ptr_d;
   logic [aw:0]           count_q, count_d;
   logic [w_x:0]          mem_q [depth];
   logic [w_x:0]          rd_ent;
   logic signed [w_x-1:0] x_q, x_d;
   logic                  x_valid_q, x_valid_d;
   logic                  fin_q, fin_d;
   logic                  done_q, done_d;
   logic                  push, pop, pop_last;

   assign coef_ready = (state_q == LOAD) && !reset;
   assign s_ready    = (count_q != full_cnt) && !reset;
   assign push       = s_valid && s_ready;
   assign pop        = (state_q == RUN) && (count_q != '0);
   assign rd_ent     = mem_q[rd_ptr_q];
   assign pop_last   = rd_ent[w_x];
   assign shadow_nx  = (shadow_q << w_h) | hw'($unsigned(coef_data));

   assign x       = x_q;
   assign x_valid = x_valid_q;
   assign Hz      = hz_q;
   assign done    = flush_en & done_q;

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      hz_d      = hz_q;
      wcnt_d    = wcnt_q;
      fcnt_d    = fcnt_q;
      wr_ptr_d  = wr_ptr_q + aw'(push);
      rd_ptr_d  = rd_ptr_q + aw'(pop);
      count_d   = count_q + (aw + 1)'(push) - (aw + 1)'(pop);
      x_d       = '0;
      x_valid_d = 1'b0;
      fin_d     = 1'b0;
      done_d    = fin_q;

      case (state_q)
         LOAD: begin
            if (coef_valid) begin
               if (wcnt_q == cw'(n)) begin
                  // Full set collected: publish to Hz in one step so the filter never sees a mix.
                  hz_d     = shadow_nx;
                  shadow_d = '0;
                  wcnt_d   = '0;
                  state_d  = RUN;
               end else begin
                  shadow_d = shadow_nx;
                  wcnt_d   = wcnt_q + 1'b1;
               end
            end
         end
         RUN: begin
            if (pop) begin
               x_d       = rd_ent[w_x-1:0];
               x_valid_d = 1'b1;
               if (pop_last && flush_en) begin
                  if (n == 0) begin
                     fin_d = 1'b1;
                  end else begin
                     state_d = FLUSH;
                     fcnt_d  = '0;
                  end
               end
            end else if (reload) begin
               state_d  = LOAD;
               shadow_d = '0;
               wcnt_d   = '0;
            end
         end
         FLUSH: begin
            x_valid_d = 1'b1;
            if (fcnt_q == cw'(n - 1)) begin
               state_d = RUN;
               fcnt_d  = '0;
               fin_d   = 1'b1;
            end else begin
               fcnt_d = fcnt_q + 1'b1;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= LOAD;
         shadow_q  <= '0;
         hz_q      <= '0;
         wcnt_q    <= '0;
         fcnt_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         x_q       <= '0;
         x_valid_q <= 1'b0;
         fin_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         hz_q      <= hz_d;
         wcnt_q    <= wcnt_d;
         fcnt_q    <= fcnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         fin_q     <= fin_d;
         done_q    <= done_d;
      end
   end

   // Storage needs no reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {s_last, s_data};
      end
   end
endmodule
